// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address-split helpers for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The cache geometry is configured here; every other file derives its widths from these constants.
package dcache_pkg;

    localparam int DEF_INDEX_W    = 8;   // log2(lines)
    localparam int DEF_WORD_OFF_W = 2;   // log2(32-bit words per line)
    localparam int TAG_W          = 32 - DEF_INDEX_W - DEF_WORD_OFF_W - 2;
    localparam int LINES          = 1 << DEF_INDEX_W;
    localparam int WORDS          = 1 << DEF_WORD_OFF_W;
    localparam int LINE_W         = 32 << DEF_WORD_OFF_W;
    localparam int OFF_W          = DEF_WORD_OFF_W + 2;  // byte offset bits inside a line

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } dcache_state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic logic [DEF_INDEX_W-1:0] get_index(input logic [31:0] a);
        return a[OFF_W +: DEF_INDEX_W];
    endfunction

    function automatic logic [DEF_WORD_OFF_W-1:0] get_word(input logic [31:0] a);
        return a[2 +: DEF_WORD_OFF_W];
    endfunction

endpackage

// File: rtl/dcache_direct_if.sv
// CPU cache port plus line-wide memory controller port of the data cache.
// Latency: n/a (wires only).
// Backpressure: CPU stalls on miss; memory side holds mem_req until a mem_ready pulse.
//
// Ports: addr/wdata/read_enable/write_enable -> rdata/miss (CPU side);
//        mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready (memory side).
// slave = the cache, master = the CPU/memory environment driving it.
interface dcache_direct_if;
    import dcache_pkg::*;

    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              write_enable;
    logic              read_enable;
    logic [31:0]       rdata;
    logic              miss;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  addr, wdata, write_enable, read_enable, mem_rdata, mem_ready,
        output rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output addr, wdata, write_enable, read_enable, mem_rdata, mem_ready,
        input  rdata, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_data_ram.sv
// Line-wide data store: async read, sync write with per-word enables.
// Latency: read combinational, write visible the cycle after the edge.
// Backpressure: none; a write happens whenever any wmask_i bit is set.
//
// Ports: raddr_i -> rdata_o (async); waddr_i/wmask_i/wdata_i written at posedge clk.
// Contents are intentionally not reset.
module dcache_data_ram #(
    parameter int IDX_W = 8,
    parameter int NWORD = 4
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [32*NWORD-1:0]   rdata_o,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [NWORD-1:0]      wmask_i,
    input  logic [32*NWORD-1:0]   wdata_i
);

    logic [32*NWORD-1:0] mem_q [1 << IDX_W];

    always_ff @(posedge clk) begin
        for (int w = 0; w < NWORD; w++) begin
            if (wmask_i[w]) begin
                mem_q[waddr_i][32*w +: 32] <= wdata_i[32*w +: 32];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back write-allocate data cache (geometry from dcache_pkg).
// Latency: hits same cycle; miss = optional line writeback, then line fill, then a hit cycle.
// Backpressure: miss stalls the CPU combinationally; mem_req held until mem_ready.
//
// Ports: clk, rstn (async active-low), bus (dcache_direct_if.slave).
// Optional macro DCACHE_STAT_EN adds saturating counters stat_hit/stat_miss.
module dcache_direct
    import dcache_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    dcache_direct_if.slave  bus
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]     stat_hit,
    output logic [31:0]     stat_miss
`endif
);

    dcache_state_t           state_q;
    logic [LINES-1:0]        valid_q, dirty_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    // The requested line is latched at miss time so a flushed request still installs correctly.
    logic [TAG_W-1:0]        fill_tag_q;
    logic [DEF_INDEX_W-1:0]  fill_idx_q;
    logic                    mem_req_q, mem_we_q;
    logic [31:0]             mem_addr_q;
    logic [LINE_W-1:0]       mem_wdata_q;

    logic                    req_w, hit_w, miss_w, store_w, fill_done_w;
    logic [TAG_W-1:0]        tag_w;
    logic [DEF_INDEX_W-1:0]  idx_w, wr_idx_w;
    logic [DEF_WORD_OFF_W-1:0] word_w;
    logic [LINE_W-1:0]       rd_line_w, wr_line_w;
    logic [WORDS-1:0]        wr_mask_w;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^bus.addr[1:0];

    always_comb begin
        req_w       = bus.read_enable | bus.write_enable;
        tag_w       = get_tag(bus.addr);
        idx_w       = get_index(bus.addr);
        word_w      = get_word(bus.addr);
        hit_w       = req_w && (state_q == IDLE) && valid_q[idx_w] && (tag_q[idx_w] == tag_w);
        miss_w      = req_w && !hit_w;
        store_w     = hit_w && bus.write_enable;
        fill_done_w = (state_q == FILL) && bus.mem_ready;
        // Fill and store never coincide: stores only happen on an IDLE hit.
        wr_idx_w    = fill_done_w ? fill_idx_q : idx_w;
        wr_mask_w   = '0;
        wr_line_w   = {WORDS{bus.wdata}};
        if (fill_done_w) begin
            wr_mask_w = '1;
            wr_line_w = bus.mem_rdata;
        end else if (store_w) begin
            wr_mask_w[word_w] = 1'b1;
        end
    end

    dcache_data_ram #(.IDX_W(DEF_INDEX_W), .NWORD(WORDS)) u_ram (
        .clk     (clk),
        .raddr_i (idx_w),
        .rdata_o (rd_line_w),
        .waddr_i (wr_idx_w),
        .wmask_i (wr_mask_w),
        .wdata_i (wr_line_w)
    );

    assign bus.rdata     = rd_line_w[32*word_w +: 32];
    assign bus.miss      = miss_w;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            fill_tag_q  <= '0;
            fill_idx_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_w) begin
                        dirty_q[idx_w] <= 1'b1;
                    end
                    if (miss_w) begin
                        fill_tag_q <= tag_w;
                        fill_idx_q <= idx_w;
                        mem_req_q  <= 1'b1;
                        if (valid_q[idx_w] && dirty_q[idx_w]) begin
                            state_q     <= WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx_w], idx_w, {OFF_W{1'b0}}};
                            mem_wdata_q <= rd_line_w;
                        end else begin
                            state_q    <= FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {tag_w, idx_w, {OFF_W{1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        state_q    <= FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {fill_tag_q, fill_idx_q, {OFF_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        state_q             <= IDLE;
                        mem_req_q           <= 1'b0;
                        valid_q[fill_idx_q] <= 1'b1;
                        dirty_q[fill_idx_q] <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_done_w) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

`ifdef DCACHE_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else begin
            if (hit_w && (stat_hit != 32'hFFFF_FFFF)) begin
                stat_hit <= stat_hit + 32'd1;
            end
            if ((state_q == IDLE) && miss_w && (stat_miss != 32'hFFFF_FFFF)) begin
                stat_miss <= stat_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: directed vector table, multi-cycle corner sequences, randomized traffic.
// Latency: n/a.
// Backpressure: the bench plays the memory controller with a programmable ready latency.
module tb_dcache_direct;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcache_direct_if bus();
`ifdef DCACHE_STAT_EN
    logic [31:0] stat_hit, stat_miss;
`endif

    dcache_direct dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef DCACHE_STAT_EN
        ,
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Backing memory (what the controller holds) and reference memory (what the CPU should see).
    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Line-level reference of the cache contents.
    bit          m_valid [256];
    bit          m_dirty [256];
    int unsigned m_tag   [256];

    typedef struct {
        logic        rd, wr;
        logic [31:0] a, wd;
        logic        exp_miss, exp_wb;
        logic [31:0] exp_wb_addr, exp_wb_w1, exp_fill;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_b(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [LINE_W-1:0] bline(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < WORDS; w++) l[32*w +: 32] = rd_b(la + 32'(4*w));
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset loses dirty data: the CPU view falls back to what memory holds.
    task automatic model_reset();
        ref_mem = bmem;
        exp_hits = 0;
        exp_misses = 0;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i] = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        rstn = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, output logic miss0, output logic wb, output logic first_we,
                          output logic [31:0] wb_addr, output logic [LINE_W-1:0] wb_line,
                          output logic [31:0] fill_addr, output logic [31:0] rd_data, output int mcycles);
        int cnt;
        logic seen;
        cnt = 0; seen = 0; wb = 0; first_we = 0; wb_addr = 0; wb_line = '0; fill_addr = 0; mcycles = 0;
        bus.read_enable = rd;
        bus.write_enable = wr;
        bus.addr = a;
        bus.wdata = wd;
        #2;
        miss0 = bus.miss;
        if (miss0 === 1'b1) exp_misses++;
        while (bus.miss === 1'b1 && mcycles < 200) begin
            if (bus.mem_req === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    first_we = bus.mem_we;
                end
                if (cnt == lat) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we === 1'b1) begin
                        wb = 1;
                        wb_addr = bus.mem_addr;
                        wb_line = bus.mem_wdata;
                        for (int w = 0; w < WORDS; w++) bmem[wb_addr + 32'(4*w)] = wb_line[32*w +: 32];
                    end else begin
                        fill_addr = bus.mem_addr;
                        bus.mem_rdata = bline(bus.mem_addr);
                    end
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            mcycles++;
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            #1;
        end
        if (bus.miss !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: miss stuck at %b for addr %h", bus.miss, a);
        end else begin
            exp_hits++;
        end
        rd_data = bus.rdata;
        tick();
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
    endtask

    vec_t tv [5];
    logic m0, wb, fwe;
    logic [31:0] wba, fa, rdv;
    logic [LINE_W-1:0] wbl;
    int mc;

    initial begin
        bus.addr = '0;
        bus.wdata = '0;
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        bmem[32'h1000] = 32'hDEAD_BEEF;
        model_reset();

        tv[0] = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1000, 1'b1, 32'hDEAD_BEEF};
        tv[1] = '{1'b0, 1'b1, 32'h1004, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b0, 32'h1004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234_5678};
        tv[3] = '{1'b1, 1'b0, 32'h2004, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h1234_5678, 32'h2000, 1'b1, init_val(32'h2004)};
        tv[4] = '{1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h3000, 1'b1, init_val(32'h3000)};

        // Reset state
        #12;
        rstn = 1'b1;
        #1;
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata_lo", bus.mem_wdata[31:0], 32'h0);
        chk("rst_miss_idle", {31'b0, bus.miss}, 32'h0);
        tick();

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            int lat;
            lat = i % 3;
            access(tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd, lat, m0, wb, fwe, wba, wbl, fa, rdv, mc);
            chk($sformatf("v%0d_miss", i), {31'b0, m0}, {31'b0, tv[i].exp_miss});
            chk($sformatf("v%0d_wb", i), {31'b0, wb}, {31'b0, tv[i].exp_wb});
            if (tv[i].exp_miss) begin
                chk($sformatf("v%0d_first_we", i), {31'b0, fwe}, {31'b0, tv[i].exp_wb});
                chk($sformatf("v%0d_fill_addr", i), fa, tv[i].exp_fill);
                chk($sformatf("v%0d_miss_cycles", i), mc, tv[i].exp_wb ? 2*lat + 3 : lat + 2);
            end
            if (tv[i].exp_wb) begin
                chk($sformatf("v%0d_wb_addr", i), wba, tv[i].exp_wb_addr);
                chk($sformatf("v%0d_wb_word1", i), wbl[63:32], tv[i].exp_wb_w1);
            end
            if (tv[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdv, tv[i].exp_rd);
        end

        // Flush during FILL: request dropped, line still installs
        bus.read_enable = 1'b1;
        bus.addr = 32'h5010;
        #2;
        chk("flush_miss", {31'b0, bus.miss}, 32'h1);
        exp_misses++;
        tick();
        #1;
        chk("flush_req", {31'b0, bus.mem_req}, 32'h1);
        chk("flush_we", {31'b0, bus.mem_we}, 32'h0);
        chk("flush_addr", bus.mem_addr, 32'h5010);
        bus.read_enable = 1'b0;
        #1;
        chk("flush_miss_noreq", {31'b0, bus.miss}, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = bline(32'h5010);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("flush_req_done", {31'b0, bus.mem_req}, 32'h0);

        // mem_ready in IDLE must be ignored
        bus.mem_rdata = '1;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        access(1'b1, 1'b0, 32'h5010, 32'h0, 0, m0, wb, fwe, wba, wbl, fa, rdv, mc);
        chk("flush_hit", {31'b0, m0}, 32'h0);
        chk("flush_rdata", rdv, init_val(32'h5010));

        // Reset while in FILL
        bus.read_enable = 1'b1;
        bus.addr = 32'h4000;
        #2;
        chk("rstfill_miss", {31'b0, bus.miss}, 32'h1);
        tick();
        #1;
        chk("rstfill_req_pre", {31'b0, bus.mem_req}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("rstfill_req_drop", {31'b0, bus.mem_req}, 32'h0);
        bus.read_enable = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h5010, 32'h0, 1, m0, wb, fwe, wba, wbl, fa, rdv, mc);
        chk("rstfill_valid_cleared", {31'b0, m0}, 32'h1);
        chk("rstfill_rdata", rdv, ref_val(32'h5010));

        // Randomized traffic against the line-level reference
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wd;
            int unsigned idx, tg;
            int op, lat;
            bit pm, pwb;
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
            wd = $urandom;
            op = $urandom_range(0, 2);
            lat = $urandom_range(0, 2);
            idx = (a >> 4) & 255;
            tg = a >> 10;
            pm = !(m_valid[idx] && m_tag[idx] == tg);
            pwb = pm && m_valid[idx] && m_dirty[idx];
            access(op != 1, op != 0, a, wd, lat, m0, wb, fwe, wba, wbl, fa, rdv, mc);
            chk($sformatf("r%0d_miss", n), {31'b0, m0}, {31'b0, pm});
            chk($sformatf("r%0d_wb", n), {31'b0, wb}, {31'b0, pwb});
            if (pwb) begin
                logic [31:0] va;
                va = (m_tag[idx] << 10) | (idx << 4);
                chk($sformatf("r%0d_wb_addr", n), wba, va);
                for (int w = 0; w < WORDS; w++)
                    chk($sformatf("r%0d_wb_w%0d", n, w), wbl[32*w +: 32], ref_val(va + 32'(4*w)));
            end
            if (pm) begin
                chk($sformatf("r%0d_fill_addr", n), fa, a & ~32'hF);
                chk($sformatf("r%0d_cycles", n), mc, pwb ? 2*lat + 3 : lat + 2);
                m_valid[idx] = 1;
                m_tag[idx] = tg;
                m_dirty[idx] = 0;
            end
            if (op == 0) chk($sformatf("r%0d_rdata", n), rdv, ref_val(a));
            if (op != 0) begin
                m_dirty[idx] = 1;
                ref_mem[a] = wd;
            end
        end

`ifdef DCACHE_STAT_EN
        #1;
        chk("stat_hit", stat_hit, exp_hits);
        chk("stat_miss", stat_miss, exp_misses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the external memory controller.
- Serves word loads and stores from the CPU cache port.
- Hits complete in the same cycle. Misses raise `miss` while the cache writes back a dirty victim line, if any, and then fills the requested line over a line-wide request/ready handshake.

Parameters:
- INDEX_W, 8, log2 of the number of lines (256 lines).
- WORD_OFF_W, 2, log2 of 32-bit words per line (4 words, 16 B lines).
- TAG_W, 32-INDEX_W-WORD_OFF_W-2, tag width; derived, not overridable.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- addr  in  32  CPU byte address, word aligned; bits[1:0] ignored
- wdata  in  32  store data
- write_enable  in  1  store request
- read_enable  in  1  load request
- rdata  out  32  load data, combinational, valid when read_enable && !miss
- miss  out  1  combinational; CPU must stall and hold addr/wdata/enables stable while high
- mem_req  out  1  memory transaction request, held until mem_ready
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  32  line-aligned byte address (low WORD_OFF_W+2 bits zero)
- mem_wdata  out  32<<WORD_OFF_W  victim line data, word 0 in LSBs
- mem_rdata  in  32<<WORD_OFF_W  fill line data, sampled when mem_ready && !mem_we
- mem_ready  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - tag = addr[31 -: TAG_W]
  - index = addr[WORD_OFF_W+2 +: INDEX_W]
  - word = addr[2 +: WORD_OFF_W]
- Storage:
  - Per line: valid, dirty, tag in flops.
  - Data array: asynchronous-read, synchronous-write LUTRAM.
- Request: req = read_enable | write_enable. If both are high, the access is treated as a write; rdata is still driven.
- hit = req && state==IDLE && valid[index] && tag match.
- miss = req && !hit. It rises combinationally in the same cycle as the request.
- Read hit: rdata = selected word in the same cycle; miss=0; zero extra latency.
- Write hit: the word is written at the clock edge where miss=0, and dirty[index] is set. A back-to-back read of the same address in the next cycle returns the new data.
- FSM states are IDLE, WB, FILL:
  - IDLE → WB on a miss with the victim valid and dirty. mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim line.
  - IDLE → FILL on a miss with the victim clean or invalid. mem_req=1, mem_we=0, mem_addr={req tag,index,0}.
  - WB → FILL on mem_ready; mem_req stays high with mem_we=0.
  - FILL → IDLE on mem_ready. The line is written from mem_rdata, valid=1, dirty=0, tag updated.
  - The following cycle re-evaluates as a hit; a store then merges and sets dirty. A miss without a writeback therefore takes fill latency + 1 cycle.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until mem_ready.
- mem_ready in IDLE is ignored.
- If req drops during WB or FILL (pipeline flush), the transaction still completes and the line is installed; no CPU write occurs.
- Reset (asynchronous, any state):
  - All valid and dirty bits are 0; state = IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Any in-flight memory transaction is abandoned; the controller must tolerate this.
  - Data array contents are not reset.
- miss=0 whenever req=0. rdata is don't-care when there is no read hit.

Optional Feature:
- Macro: DCACHE_STAT_EN.
- Defined: adds outputs stat_hit[31:0] and stat_miss[31:0].
  - stat_hit increments on each cycle with hit=1.
  - stat_miss increments once per IDLE→WB or IDLE→FILL transition.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - enum dcache_state_t {IDLE, WB, FILL}.
  - Default INDEX_W and WORD_OFF_W constants.
  - Line-width localparam.
  - Helper functions get_tag, get_index and get_word.
- Sub-module dcache_data_ram:
  - Parameterised LUTRAM: 2^INDEX_W entries of a full line.
  - One async read port.
  - One write port with per-word enable, used for the store merge and the full-line fill.

Test Plan:
- Reset, then read 0x0000_1000 → miss=1 in the same cycle, mem_req=1, mem_we=0, mem_addr=0x1000. Return mem_rdata word0=0xDEADBEEF with a one-cycle mem_ready → the next cycle shows miss=0, rdata=0xDEADBEEF.
- Write 0x1004 ← 0x12345678 after that fill → miss=0, 1-cycle write. Read 0x1004 next cycle → 0x12345678.
- Read 0x0000_2004, same index, different tag, with the dirty line present → mem_we=1, mem_addr=0x1000, mem_wdata word1=0x12345678. After mem_ready: mem_we=0, mem_addr=0x2000. After the second mem_ready: hit.
- Read 0x3000 (clean victim at index 0) → no WB phase; the first request has mem_we=0.
- Assert rstn=0 during FILL → mem_req drops immediately; after release, read 0x1000 → miss again (valid cleared).
- Drop read_enable in FILL, then return mem_ready → the line installs; a later read of the same address hits. With DCACHE_STAT_EN defined, counters match the totals of hit cycles and miss transitions issued.
